// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] diff;

  assign t    = {rem, din};
  assign qbit = (t >= {1'b0, divisor});
  // Whenever the subtraction is kept, t - divisor < divisor, so the low bits are exact.
  assign diff     = t[WIDTH-1:0] - divisor;
  assign rem_next = qbit ? diff : t[WIDTH-1:0];

endmodule

// File: rtl/divider_restoring_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional zero-divisor short-cut and flag: define DIV_ZERO_CHECK_EN.
module divider_restoring_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] areg, breg, rem, qacc, qacc_nx, rem_nx;
  logic             qbit, accept, zskip;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .din     (areg[cnt]),
    .divisor (breg),
    .rem_next(rem_nx),
    .qbit    (qbit)
  );

`ifdef DIV_ZERO_CHECK_EN
  logic dz_q;
  assign zskip       = (breg == '0);
  assign div_by_zero = dz_q;
`else
  assign zskip       = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    valid    = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (zskip || cnt == '0) state_nx = DONE;
      end
      DONE: begin
        ready = 1'b1;
        valid = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    qacc_nx      = qacc;
    qacc_nx[cnt] = qbit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg <= '0;
      breg <= '0;
      rem  <= '0;
      qacc <= '0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dz_q <= 1'b0;
`endif
    end else if (accept) begin
      areg <= a;
      breg <= b;
      rem  <= '0;
      qacc <= '0;
      cnt  <= CW'(WIDTH - 1);
`ifdef DIV_ZERO_CHECK_EN
      dz_q <= 1'b0;
`endif
    end else if (state == RUN) begin
      if (zskip) begin
        // Same result the full iteration would give, without spending the cycles.
        q <= '1;
        r <= areg;
`ifdef DIV_ZERO_CHECK_EN
        dz_q <= 1'b1;
`endif
      end else begin
        rem  <= rem_nx;
        qacc <= qacc_nx;
        cnt  <= cnt - 1'b1;
        if (cnt == '0) begin
          q <= qacc_nx;
          r <= rem_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_restoring_seq.sv
// Self-checking bench for divider_restoring_seq (WIDTH=4) against an arithmetic reference model.
module tb_divider_restoring_seq;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         ready, valid, div_by_zero;
  logic [W-1:0] q, r;

  int vectors    = 0;
  int miscompares = 0;

  divider_restoring_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .valid      (valid),
    .q          (q),
    .r          (r),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input int av, input int bv, output int qv, output int rv);
    if (bv == 0) begin
      qv = MAXV;
      rv = av;
    end else begin
      qv = av / bv;
      rv = av % bv;
    end
  endfunction

  function automatic int latency(input int bv);
    return (DZ_EN && bv == 0) ? 2 : W + 1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: edges remaining until the accepted result is due.
  int remaining = 0;
  bit have      = 1'b0;
  int exp_q = 0, exp_r = 0, exp_dz = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining = 0;
      have      = 1'b0;
    end else if (start && remaining == 0) begin
      ref_div(int'(a), int'(b), exp_q, exp_r);
      exp_dz    = (DZ_EN && b == 0) ? 1 : 0;
      remaining = latency(int'(b)) - 1;
      have      = 1'b0;
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0) have = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("valid", int'(valid), int'(have && remaining == 0));
    check("ready", int'(ready), int'(remaining == 0));
    if (!rst_n) begin
      check("rst_q", int'(q), 0);
      check("rst_r", int'(r), 0);
    end else if (have && remaining == 0) begin
      check("q", int'(q), exp_q);
      check("r", int'(r), exp_r);
      check("div_by_zero", int'(div_by_zero), exp_dz);
    end
  end

  // Issue one division from a negedge; returns at the negedge where valid is seen.
  task automatic run_op(input int ai, input int bi, input bit lit, input int lq, input int lr,
                        input bit noise);
    int edges;
    @(negedge clk);
    start = 1'b1;
    a     = W'(ai);
    b     = W'(bi);
    @(negedge clk);
    edges = 1;
    start = noise;
    a     = W'($urandom_range(MAXV));
    b     = W'($urandom_range(MAXV));
    while (valid !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
      start = 1'b0;
    end
    start = 1'b0;
    check("latency", edges, latency(bi));
    if (lit) begin
      check("lit_q", int'(q), lq);
      check("lit_r", int'(r), lr);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(13, 3, 1'b1, 4, 1, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_q", int'(q), 4);
    check("hold_r", int'(r), 1);

    run_op(15, 1, 1'b1, 15, 0, 1'b0);
    run_op(2, 7, 1'b1, 0, 2, 1'b0);
    run_op(0, 5, 1'b1, 0, 0, 1'b0);
    run_op(15, 15, 1'b1, 1, 0, 1'b0);
    run_op(9, 2, 1'b1, 4, 1, 1'b0);
    run_op(9, 2, 1'b1, 4, 1, 1'b1);
    run_op(9, 0, 1'b1, 15, 9, 1'b0);
    check("dz_flag", int'(div_by_zero), DZ_EN ? 1 : 0);

    // Abort in the third RUN cycle.
    @(negedge clk);
    start = 1'b1;
    a     = W'(13);
    b     = W'(3);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_valid", int'(valid), 0);
    check("abort_ready", int'(ready), 1);
    check("abort_q", int'(q), 0);
    check("abort_r", int'(r), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(6, 4, 1'b1, 1, 2, 1'b0);

    for (int ai = 0; ai <= MAXV; ai++)
      for (int bi = 1; bi <= MAXV; bi++)
        run_op(ai, bi, 1'b0, 0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(2)) @(negedge clk);
      run_op(int'($urandom_range(MAXV)), int'($urandom_range(MAXV)), 1'b0, 0, 0,
             1'($urandom_range(1)));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
